// File: rtl/hit_judge_if.sv
// Bundles the game-control inputs and the score outputs of the hit judge.
// The slave modport is the judge, and the master modport is whatever drives it.
interface hit_judge_if;
  logic       start;
  logic       light_on;
  logic [3:0] light_pos;
  logic       key_valid;
  logic [3:0] key;
  logic       lives_mode;
  logic [5:0] score;
  logic [5:0] misses;
  logic [1:0] lives_left;
  logic       hit;
  logic       miss;
  logic       dead;

  modport master (
    output start, light_on, light_pos, key_valid, key, lives_mode,
    input  score, misses, lives_left, hit, miss, dead
  );

  modport slave (
    input  start, light_on, light_pos, key_valid, key, lives_mode,
    output score, misses, lives_left, hit, miss, dead
  );
endinterface

// File: rtl/hit_judge.sv
// Registered judge: gives one hit or miss per lit target and keeps the saturating
// score and miss counters, the remaining lives and the game-over flag.
module hit_judge #(
  parameter int LIVES    = 3,
  parameter int NUM_KEYS = 9,
  parameter int CNT_MAX  = 63
) (
  input  logic        clk,
  input  logic        reset,
  hit_judge_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] JUDGED = 2'd2;
  localparam logic [1:0] OVER   = 2'd3;

  localparam logic [3:0] KEY_LIMIT  = 4'(NUM_KEYS);
  localparam logic [5:0] CNT_SAT    = 6'(CNT_MAX);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  logic [1:0] state_reg, state_next;
  logic [3:0] tgt_reg, tgt_next;
  logic       key_prev_reg, light_prev_reg;
  logic [5:0] score_reg, score_next;
  logic [5:0] misses_reg, misses_next;
  logic [1:0] lives_reg, lives_next;
  logic       hit_reg, miss_reg;
  logic       dead_reg, dead_next;

  logic press, light_rise, light_fall;
  logic judge_hit, judge_miss;

  always_comb begin
    press      = bus.key_valid & ~key_prev_reg & (bus.key < KEY_LIMIT);
    light_rise = bus.light_on & ~light_prev_reg;
    light_fall = ~bus.light_on & light_prev_reg;

    state_next = state_reg;
    tgt_next   = tgt_reg;
    judge_hit  = 1'b0;
    judge_miss = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start && light_rise) begin
          tgt_next   = bus.light_pos;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (!bus.start) begin
          state_next = IDLE;
        end else if (press) begin
          judge_hit  = (bus.key == tgt_reg);
          judge_miss = (bus.key != tgt_reg);
          // A press that coincides with the light going out still counts,
          // but the light is gone, so there is nothing left to wait for.
          state_next = light_fall ? IDLE : JUDGED;
        end else if (light_fall) begin
          judge_miss = 1'b1;
          state_next = IDLE;
        end
      end
      JUDGED: begin
        if (!bus.start || light_fall) begin
          state_next = IDLE;
        end
      end
      default: ;
    endcase

    score_next  = score_reg;
    misses_next = misses_reg;
    lives_next  = lives_reg;
    dead_next   = dead_reg;

    if (judge_hit && score_reg != CNT_SAT) begin
      score_next = score_reg + 6'd1;
    end
    if (judge_miss) begin
      if (misses_reg != CNT_SAT) begin
        misses_next = misses_reg + 6'd1;
      end
      if (bus.lives_mode && lives_reg != 2'd0) begin
        lives_next = lives_reg - 2'd1;
        if (lives_reg == 2'd1) begin
          dead_next  = 1'b1;
          state_next = OVER;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      tgt_reg        <= 4'd0;
      // Treat the key as already held so a key held through reset is not a press.
      key_prev_reg   <= 1'b1;
      light_prev_reg <= 1'b0;
      score_reg      <= 6'd0;
      misses_reg     <= 6'd0;
      lives_reg      <= LIVES_INIT;
      hit_reg        <= 1'b0;
      miss_reg       <= 1'b0;
      dead_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tgt_reg        <= tgt_next;
      key_prev_reg   <= bus.key_valid;
      light_prev_reg <= bus.light_on;
      score_reg      <= score_next;
      misses_reg     <= misses_next;
      lives_reg      <= lives_next;
      hit_reg        <= judge_hit;
      miss_reg       <= judge_miss;
      dead_reg       <= dead_next;
    end
  end

  assign bus.score      = score_reg;
  assign bus.misses     = misses_reg;
  assign bus.lives_left = lives_reg;
  assign bus.hit        = hit_reg;
  assign bus.miss       = miss_reg;
  assign bus.dead       = dead_reg;
endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: a cycle-by-cycle vector table, followed by
// hand-written sequences for lives/game-over, key-held-through-reset and saturation.
module tb_hit_judge;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  hit_judge_if bus ();

  hit_judge #(.LIVES(3), .NUM_KEYS(9), .CNT_MAX(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       lo;
    logic [3:0] lp;
    logic       kv;
    logic [3:0] k;
    logic       lm;
    logic       h;
    logic       m;
    logic [5:0] sc;
    logic [5:0] ms;
    logic [1:0] lv;
    logic       d;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic st, logic lo, logic [3:0] lp, logic kv, logic [3:0] k,
                              logic lm, logic h, logic m, logic [5:0] sc, logic [5:0] ms,
                              logic [1:0] lv, logic d);
    vec_t v;
    v.st = st; v.lo = lo; v.lp = lp; v.kv = kv; v.k = k; v.lm = lm;
    v.h = h; v.m = m; v.sc = sc; v.ms = ms; v.lv = lv; v.d = d;
    return v;
  endfunction

  task automatic drive(logic st, logic lo, logic [3:0] lp, logic kv, logic [3:0] k, logic lm);
    bus.start      = st;
    bus.light_on   = lo;
    bus.light_pos  = lp;
    bus.key_valid  = kv;
    bus.key        = k;
    bus.lives_mode = lm;
  endtask

  // Sample one time unit after the active edge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {bus.hit, bus.miss, bus.dead, bus.lives_left, bus.misses, bus.score};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

    //               st lo lp    kv k     lm   h  m  sc    ms    lv    d
    vecs[0]  = mk(1, 0, 4'd0, 0, 4'd0, 0,  0, 0, 6'd0, 6'd0, 2'd3, 0);
    vecs[1]  = mk(1, 1, 4'd4, 0, 4'd0, 0,  0, 0, 6'd0, 6'd0, 2'd3, 0);
    vecs[2]  = mk(1, 1, 4'd9, 0, 4'd0, 0,  0, 0, 6'd0, 6'd0, 2'd3, 0);
    vecs[3]  = mk(1, 1, 4'd4, 1, 4'd4, 0,  1, 0, 6'd1, 6'd0, 2'd3, 0);
    vecs[4]  = mk(1, 1, 4'd4, 1, 4'd4, 0,  0, 0, 6'd1, 6'd0, 2'd3, 0);
    vecs[5]  = mk(1, 1, 4'd4, 0, 4'd0, 0,  0, 0, 6'd1, 6'd0, 2'd3, 0);
    vecs[6]  = mk(1, 1, 4'd4, 1, 4'd4, 0,  0, 0, 6'd1, 6'd0, 2'd3, 0);
    vecs[7]  = mk(1, 0, 4'd0, 0, 4'd0, 0,  0, 0, 6'd1, 6'd0, 2'd3, 0);
    vecs[8]  = mk(1, 1, 4'd2, 0, 4'd0, 0,  0, 0, 6'd1, 6'd0, 2'd3, 0);
    vecs[9]  = mk(1, 1, 4'd2, 1, 4'd7, 0,  0, 1, 6'd1, 6'd1, 2'd3, 0);
    vecs[10] = mk(1, 1, 4'd2, 0, 4'd0, 0,  0, 0, 6'd1, 6'd1, 2'd3, 0);
    vecs[11] = mk(1, 1, 4'd2, 1, 4'd2, 0,  0, 0, 6'd1, 6'd1, 2'd3, 0);
    vecs[12] = mk(1, 0, 4'd0, 0, 4'd0, 0,  0, 0, 6'd1, 6'd1, 2'd3, 0);
    vecs[13] = mk(1, 1, 4'd5, 0, 4'd0, 1,  0, 0, 6'd1, 6'd1, 2'd3, 0);
    vecs[14] = mk(1, 0, 4'd0, 0, 4'd0, 1,  0, 1, 6'd1, 6'd2, 2'd2, 0);
    vecs[15] = mk(1, 1, 4'd6, 0, 4'd0, 1,  0, 0, 6'd1, 6'd2, 2'd2, 0);
    vecs[16] = mk(1, 0, 4'd0, 1, 4'd6, 1,  1, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[17] = mk(1, 0, 4'd0, 0, 4'd0, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[18] = mk(1, 1, 4'd1, 0, 4'd0, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[19] = mk(1, 1, 4'd1, 1, 4'd9, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[20] = mk(1, 1, 4'd1, 0, 4'd0, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[21] = mk(0, 0, 4'd0, 0, 4'd0, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[22] = mk(0, 1, 4'd3, 0, 4'd0, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[23] = mk(1, 1, 4'd3, 0, 4'd0, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[24] = mk(1, 1, 4'd3, 1, 4'd3, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[25] = mk(1, 0, 4'd0, 0, 4'd0, 1,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[26] = mk(1, 1, 4'd0, 0, 4'd0, 0,  0, 0, 6'd2, 6'd2, 2'd2, 0);
    vecs[27] = mk(1, 0, 4'd0, 0, 4'd0, 0,  0, 1, 6'd2, 6'd3, 2'd2, 0);

    step();
    step();
    check("reset_state", 32'(outs()), 32'({1'b0, 1'b0, 1'b0, 2'd3, 6'd0, 6'd0}));
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].st, vecs[i].lo, vecs[i].lp, vecs[i].kv, vecs[i].k, vecs[i].lm);
      step();
      $display("vec %0d: hit=%0b miss=%0b score=%0d misses=%0d lives=%0d dead=%0b",
               i, bus.hit, bus.miss, bus.score, bus.misses, bus.lives_left, bus.dead);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].h, vecs[i].m, vecs[i].d, vecs[i].lv, vecs[i].ms, vecs[i].sc}));
    end

    // Lives mode: three unanswered lights end the game, then nothing is judged.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'(i + 1), 1'b0, 4'd0, 1'b1);
      step();
      drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
      step();
      $display("life %0d: miss=%0b lives=%0d dead=%0b", i, bus.miss, bus.lives_left, bus.dead);
      check($sformatf("life%0d", i), 32'({bus.miss, bus.dead, bus.lives_left, bus.misses}),
            32'({1'b1, (i == 2), 2'(2 - i), 6'(i + 1)}));
      step();
    end
    drive(1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
    step();
    drive(1'b1, 1'b1, 4'd4, 1'b1, 4'd4, 1'b1);
    step();
    $display("over: hit=%0b score=%0d dead=%0b", bus.hit, bus.score, bus.dead);
    check("over_no_hit", 32'(outs()), 32'({1'b0, 1'b0, 1'b1, 2'd0, 6'd3, 6'd0}));

    // Key held across reset release and across the light rise is not a press.
    drive(1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
    do_reset();
    step();
    drive(1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
    step();
    step();
    check("held_key_no_hit", 32'({bus.hit, bus.score}), 32'({1'b0, 6'd0}));
    drive(1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0);
    step();
    drive(1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
    step();
    $display("repress: hit=%0b score=%0d", bus.hit, bus.score);
    check("repress_hit", 32'({bus.hit, bus.miss, bus.score}), 32'({1'b1, 1'b0, 6'd1}));

    // 64 hits saturate the score at 63.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    do_reset();
    step();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b1, 4'(i % 9), 1'b0, 4'd0, 1'b0);
      step();
      drive(1'b1, 1'b1, 4'(i % 9), 1'b1, 4'(i % 9), 1'b0);
      step();
      $display("sat %0d: hit=%0b score=%0d", i, bus.hit, bus.score);
      check($sformatf("sat%0d", i), 32'({bus.hit, bus.miss, bus.score}),
            32'({1'b1, 1'b0, 6'((i + 1 > 63) ? 63 : i + 1)}));
      drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step();
    end

    // Start low freezes judging and holds the score.
    drive(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    drive(1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0);
    step();
    check("frozen_press", 32'({bus.hit, bus.miss, bus.score}), 32'({1'b0, 1'b0, 6'd63}));
    drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    check("frozen_fall", 32'({bus.hit, bus.miss, bus.score, bus.misses}),
          32'({1'b0, 1'b0, 6'd63, 6'd0}));
    reset = 1'b1;
    step();
    $display("final reset: score=%0d", bus.score);
    check("reset_clears", 32'(outs()), 32'({1'b0, 1'b0, 1'b0, 2'd3, 6'd0, 6'd0}));
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Scoring stage directly downstream of the light controller and the keypad controller, and upstream of the score/lives displays.
- Compares each debounced keypad press against the currently lit target and issues exactly one judgement (hit or miss) per lit light.
- Maintains the player score, the miss count and the remaining lives, and raises a game-over flag for lives mode.
- Replaces ad-hoc combinational hit counting with a registered, edge-qualified judge.

Parameters:
LIVES, 3, initial lives in lives mode (1..3, fits 2 bits)
NUM_KEYS, 9, valid key/light indices are 0..NUM_KEYS-1
CNT_MAX, 63, saturation value of score and misses (6-bit)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
start  in  1  level, high while the game is in PLAY; low freezes judging
light_on  in  1  level, high while a target light is lit
light_pos  in  4  index of the lit target, sampled only on the light_on rising edge
key_valid  in  1  level, high while a decoded key is held
key  in  4  index of the held key
lives_mode  in  1  1 = misses cost lives
score  out  6  correct hits, saturating
misses  out  6  missed or wrong judgements, saturating
lives_left  out  2  remaining lives
hit  out  1  one-cycle pulse per hit
miss  out  1  one-cycle pulse per miss
dead  out  1  level, lives exhausted in lives mode

Behaviour:
- Reset (synchronous, active-high, highest priority, any state) sets:
  - score = 0, misses = 0, lives_left = LIVES, hit = 0, miss = 0, dead = 0;
  - state = IDLE, tgt = 0;
  - key_prev = 1, so a key already held when reset releases is not a press;
  - light_prev = 0.
- Edge detection:
  - press = key_valid & ~key_prev & (key < NUM_KEYS).
  - light_rise = light_on & ~light_prev.
  - light_fall = ~light_on & light_prev.
  - key_prev and light_prev register every cycle, regardless of start.
- States: IDLE, ARMED, JUDGED, OVER.
  - IDLE: on light_rise with start = 1, latch tgt = light_pos and go to ARMED. A press in IDLE is ignored.
  - ARMED, press with key == tgt: hit, go to JUDGED.
  - ARMED, press with key != tgt: miss, go to JUDGED.
  - ARMED, light_fall with no press in the same cycle: miss, go to IDLE.
  - ARMED, press and light_fall in the same cycle: the press is judged against tgt, then go to IDLE.
  - JUDGED: further presses are ignored. On light_fall go to IDLE.
  - OVER: all inputs are ignored; leave only via reset.
- Changes on light_pos while light_on stays high are ignored. Only the rising edge sets the target.
- A light that rises while start = 0 is never judged.
- Latency: the event is detected in cycle N. hit or miss is high for exactly cycle N+1, and the counters show their new values in cycle N+1.
- On hit: score = min(score+1, CNT_MAX).
- On miss:
  - misses = min(misses+1, CNT_MAX).
  - If lives_mode = 1 and lives_left > 0, lives_left decrements.
  - If that decrement reaches 0: dead = 1 in the same cycle N+1 and state = OVER.
- lives_mode = 0: lives_left holds at its current value and dead stays 0.
- start = 0 (any state except OVER):
  - state forced to IDLE, no judgements;
  - score, misses and lives_left hold, so the final score stays displayed;
  - counters are cleared only by reset.
- hit and miss are never high in the same cycle.

Test Plan:
- Reset, start = 1, light_on rises with light_pos = 4, key 4 pressed 10 cycles later -> hit pulse 1 cycle, score 0 -> 1, misses 0.
- Target 2, key 7 pressed, then key 2 pressed while the light is still on -> one miss pulse only, misses = 1, score = 0, second press ignored.
- Target 5, light_on falls with no press -> miss next cycle, misses = 1. With lives_mode = 1 and LIVES = 3: lives_left 3 -> 2.
- lives_mode = 1, three consecutive unpressed lights -> lives_left 3, 2, 1, 0; dead = 1 together with the third miss pulse; a fourth light plus a correct key gives no hit and score is unchanged.
- Key 3 held across reset release and across a target-3 light rise -> no hit. Release and re-press -> hit, score = 1.
- 64 consecutive hits -> score saturates at 63. Then drop start -> score holds at 63 and no pulses occur. Assert reset -> score = 0 on the next cycle.
